// File: rtl/rr_arbiter_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

endpackage

// File: rtl/rr_pick_8.sv
// Rotating priority picker: first set request at or after ptr, mod 8.
module rr_pick_8
    import rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] enc;

    // Rotate right so requester ptr lands on bit 0.
    assign rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        enc      = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc      = IDX_W'(i);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_idx = enc + ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with done release and hold timeout.
module rr_arbiter_8
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int LAST_I = (MAX_HOLD < 1) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LAST_I);

    arb_state_t       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             gnt_valid_q;
    logic             timeout_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             hold_exp;

    rr_pick_8 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    assign hold_exp = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q     <= BUSY;
                        gnt_q       <= N_REQ'(1) << pick_idx;
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    // done takes precedence, so a coincident expiry is not a timeout
                    if (done || hold_exp) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + IDX_W'(1);
                        timeout_q   <= ~done;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomized and directed bench for rr_arbiter_8 against a behavioural model.
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_pass = 0;
    int n_total = 0;
    bit armed = 1'b0;

    // Model state: owner, how many cycles the grant has been visible, next priority.
    bit m_busy;
    int m_idx;
    int m_age;
    int m_ptr;
    bit m_to;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic int mpick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_idx = 0; m_age = 0; m_ptr = 0; m_to = 0;
        end else begin
            int p;
            m_to = 0;
            if (!m_busy) begin
                p = mpick(req, m_ptr);
                if (p >= 0) begin
                    m_busy = 1; m_idx = p; m_age = 1;
                end
            end else if (done || m_age == MAXH) begin
                m_to = !done;
                m_busy = 0;
                m_ptr = (m_idx + 1) % 8;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [7:0] eg;
            eg = m_busy ? (8'h01 << m_idx) : 8'h00;
            chk("gnt", gnt, eg);
            chk("gnt_idx", gnt_idx, m_idx);
            chk("gnt_valid", gnt_valid, m_busy);
            chk("timeout", timeout, m_to);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step();
        armed = 1'b1;
        step();
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_idx", gnt_idx, 3'd0);

        // single request then done; ptr should land on 3
        rst = 1'b0; req = 8'h04;
        step();
        chk("single_gnt", gnt, 8'h04);
        chk("single_idx", gnt_idx, 3'd2);
        done = 1'b1;
        step();
        chk("single_release", gnt, 8'h00);
        done = 1'b0; req = 8'h0C;
        step();
        chk("ptr_after_2", gnt_idx, 3'd3);
        done = 1'b1; req = 8'h00;
        step();
        done = 1'b0;

        // fairness from reset with all requesting
        rst = 1'b1;
        step();
        rst = 1'b0; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_seq", gnt_idx, i % 8);
            done = 1'b1;
            step();
            chk("rr_bubble", gnt_valid, 1'b0);
            done = 1'b0;
        end
        req = 8'h00;
        step();

        // wrap and skip: serve 5, then 8'h09 goes 0 then 3
        req = 8'h20;
        step();
        chk("serve5", gnt_idx, 3'd5);
        done = 1'b1; req = 8'h09;
        step();
        done = 1'b0;
        step();
        chk("wrap_to0", gnt, 8'h01);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("skip_to3", gnt, 8'h08);
        done = 1'b1; req = 8'h00;
        step();
        done = 1'b0;

        // timeout on requester 7
        req = 8'h80;
        for (int i = 0; i < MAXH; i++) begin
            step();
            chk("hold_gnt", gnt, 8'h80);
            chk("hold_no_to", timeout, 1'b0);
        end
        step();
        chk("to_gnt", gnt, 8'h00);
        chk("to_pulse", timeout, 1'b1);
        req = 8'h81;
        step();
        chk("to_ptr0", gnt_idx, 3'd0);
        chk("to_one_cycle", timeout, 1'b0);
        done = 1'b1; req = 8'h00;
        step();
        done = 1'b0;

        // done in the final hold cycle
        req = 8'h10;
        step();
        repeat (MAXH - 1) step();
        done = 1'b1;
        step();
        chk("done_last_gnt", gnt, 8'h00);
        chk("done_last_to", timeout, 1'b0);

        // done while idle
        req = 8'h00;
        step();
        step();
        chk("idle_done", gnt_valid, 1'b0);
        done = 1'b0;

        // owner drops request while busy
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        chk("drop_req_hold", gnt, 8'h02);
        repeat (MAXH - 1) step();
        chk("drop_req_to", timeout, 1'b1);

        // reset mid-grant
        req = 8'h20;
        step();
        chk("pre_rst_idx", gnt_idx, 3'd5);
        rst = 1'b1;
        step();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_idx", gnt_idx, 3'd0);
        rst = 1'b0; req = 8'hFF;
        step();
        chk("post_rst_idx", gnt_idx, 3'd0);
        done = 1'b1;
        step();
        done = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req  = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; req = 8'h00; done = 1'b0;
        step();
        @(negedge clk);
        #1;
        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
